// File: rtl/sort_chunk_loader_pkg.sv
// sort_chunk_loader_pkg
//   Shared definitions for the chunk loader and the pad record generator:
//   - state_t        : loader FSM encoding (FILL=0, PAD=1)
//   - nb_of()        : beats per chunk, 2^(P_LOG-E_LOG)
//   - sentinel_key() : maximum-key sentinel for a given key format, returned
//                      right-aligned in 64 bits (callers keep the low KEYW bits)
package sort_chunk_loader_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

    function automatic int nb_of(input int p_log, input int e_log);
        return 1 << (p_log - e_log);
    endfunction

    // Key that sorts above every legal key. Supports KEYW up to 64.
    // Float keys use +inf so NaN-free data never outranks the sentinel.
    function automatic logic [63:0] sentinel_key(input bit is_float,
                                                 input bit is_signed,
                                                 input int keyw);
        logic [63:0] key;
        if (is_float) begin
            key = (keyw == 64) ? 64'h7FF0_0000_0000_0000 : 64'h0000_0000_7F80_0000;
        end else if (is_signed) begin
            key = (64'd1 << (keyw - 1)) - 64'd1;
        end else if (keyw >= 64) begin
            key = '1;
        end else begin
            key = (64'd1 << keyw) - 64'd1;
        end
        return key;
    endfunction

endpackage

// File: rtl/sort_chunk_loader_if.sv
// sort_chunk_loader_if
//   Bundles the narrow input stream and the wide chunk output of the loader.
//   Ports (signals):
//     IN_DATA  [DATW<<E_LOG] input beat, lane j at bits [DATW*(j+1)-1:DATW*j]
//     IN_VALID, IN_LAST       beat valid / final beat of stream
//     IN_READY                loader can take a beat this cycle
//     OUT_DATA [DATW<<P_LOG]  emitted chunk, slot s at [DATW*(s+1)-1:DATW*s]
//     OUT_EN                  one-cycle chunk pulse
//     OUT_CNT  [P_LOG+1]      real records in the emitted chunk
//   Handshake: a beat transfers on a rising CLK edge where IN_VALID and
//   IN_READY are both 1; IN_LAST and IN_DATA are only meaningful on such an
//   edge. IN_READY never depends on IN_VALID. The output side has no ready:
//   OUT_EN is a strobe the consumer must take.
//   Modports: master = stream producer / chunk consumer, slave = loader.
interface sort_chunk_loader_if #(
    parameter int DATW  = 64,
    parameter int P_LOG = 9,
    parameter int E_LOG = 2
);
    logic [(DATW<<E_LOG)-1:0] IN_DATA;
    logic                     IN_VALID;
    logic                     IN_LAST;
    logic                     IN_READY;
    logic [(DATW<<P_LOG)-1:0] OUT_DATA;
    logic                     OUT_EN;
    logic [P_LOG:0]           OUT_CNT;

    modport master (
        output IN_DATA, IN_VALID, IN_LAST,
        input  IN_READY, OUT_DATA, OUT_EN, OUT_CNT
    );

    modport slave (
        input  IN_DATA, IN_VALID, IN_LAST,
        output IN_READY, OUT_DATA, OUT_EN, OUT_CNT
    );
endinterface

// File: rtl/sort_pad_record.sv
// sort_pad_record
//   Constant DATW-bit sentinel record: zero payload, maximum key in the low
//   KEYW bits. Shared with the downstream result trimmer so both agree on
//   what a filler record looks like.
//   Ports:
//     record  out  DATW  sentinel record
module sort_pad_record
    import sort_chunk_loader_pkg::*;
#(
    parameter int    DATW   = 64,
    parameter int    KEYW   = 32,
    parameter string FLOAT  = "no",
    parameter string SIGNED = "no"
) (
    output logic [DATW-1:0] record
);
    localparam bit          IS_FLOAT  = (FLOAT == "yes");
    localparam bit          IS_SIGNED = (SIGNED == "yes");
    localparam logic [63:0] KEY       = sentinel_key(IS_FLOAT, IS_SIGNED, KEYW);

    if (DATW > KEYW) begin : g_payload
        assign record = {{(DATW-KEYW){1'b0}}, KEY[KEYW-1:0]};
    end else begin : g_key_only
        assign record = KEY[DATW-1:0];
    end
endmodule

// File: rtl/sort_chunk_loader.sv
// sort_chunk_loader
//   Gathers 2^E_LOG-record beats into one 2^P_LOG-record chunk and emits it
//   as a one-cycle pulse for the EVEN_ODD sorter. A stream ending mid-chunk
//   is completed with sentinel beats (one per cycle, input stalled).
//   Ports:
//     CLK, RST   clock, synchronous active-high reset
//     bus        sort_chunk_loader_if.slave (stream in, chunk out)
//     dbg_state  current FSM state, for observation only
module sort_chunk_loader
    import sort_chunk_loader_pkg::*;
#(
    parameter int    P_LOG  = 9,
    parameter int    E_LOG  = 2,
    parameter string FLOAT  = "no",
    parameter string SIGNED = "no",
    parameter int    DATW   = 64,
    parameter int    KEYW   = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    sort_chunk_loader_if.slave   bus,
    output state_t               dbg_state
);
    localparam int LANES = 1 << E_LOG;
    localparam int BW    = DATW * LANES;
    localparam int CW    = DATW << P_LOG;
    localparam int IW    = P_LOG - E_LOG;
    localparam int NB    = nb_of(P_LOG, E_LOG);
    // With E_LOG == P_LOG the index is logically 0 bits; a 1-bit register
    // that is pinned at 0 (LAST_IDX == 0) keeps the code uniform.
    localparam int IDXW  = (IW > 0) ? IW : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);
    localparam logic [P_LOG:0]  CNT_STEP = (P_LOG+1)'(LANES);

    state_t          state, state_n;
    logic [IDXW-1:0] idx;
    logic [CW-1:0]   fill_buf, fill_next;
    logic [P_LOG:0]  real_cnt, real_cnt_n;
    logic [CW-1:0]   out_data;
    logic [P_LOG:0]  out_cnt;
    logic            out_en;

    logic [DATW-1:0] pad_rec;
    logic [BW-1:0]   pad_beat, wr_beat;
    logic            in_ready, wr_en, real_wr, done;

    sort_pad_record #(
        .DATW   (DATW),
        .KEYW   (KEYW),
        .FLOAT  (FLOAT),
        .SIGNED (SIGNED)
    ) u_pad (
        .record (pad_rec)
    );

    assign pad_beat = {LANES{pad_rec}};

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle write control
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        real_wr  = 1'b0;
        wr_beat  = bus.IN_DATA;
        done     = 1'b0;
        case (state)
            FILL: begin
                // Held low during reset so nothing looks accepted then.
                in_ready = ~RST;
                if (bus.IN_VALID && in_ready) begin
                    wr_en   = 1'b1;
                    real_wr = 1'b1;
                    // A beat landing in the last position completes the
                    // chunk whether or not it carries IN_LAST.
                    if (idx == LAST_IDX) begin
                        done = 1'b1;
                    end else if (bus.IN_LAST) begin
                        state_n = PAD;
                    end
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                wr_beat = pad_beat;
                if (idx == LAST_IDX) begin
                    done    = 1'b1;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    assign real_cnt_n = real_wr ? (real_cnt + CNT_STEP) : real_cnt;

    // Chunk image including this cycle's write, so a completing beat can be
    // copied straight to the output without an extra cycle.
    always_comb begin
        fill_next = fill_buf;
        for (int k = 0; k < NB; k++) begin
            if (wr_en && (idx == IDXW'(k))) begin
                fill_next[k*BW +: BW] = wr_beat;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx      <= '0;
            fill_buf <= '0;
            real_cnt <= '0;
            out_data <= '0;
            out_cnt  <= '0;
            out_en   <= 1'b0;
        end else begin
            out_en   <= done;
            fill_buf <= fill_next;
            if (wr_en) begin
                idx <= (idx == LAST_IDX) ? '0 : (idx + 1'b1);
            end
            if (done) begin
                out_data <= fill_next;
                out_cnt  <= real_cnt_n;
                real_cnt <= '0;
            end else begin
                real_cnt <= real_cnt_n;
            end
        end
    end

    assign bus.IN_READY = in_ready;
    assign bus.OUT_DATA = out_data;
    assign bus.OUT_CNT  = out_cnt;
    assign bus.OUT_EN   = out_en;
    assign dbg_state    = state;
endmodule

// File: tb/tb_sort_chunk_loader.sv
// tb_sort_chunk_loader
//   Three P_LOG=3/E_LOG=1 loaders (unsigned, signed, float keys) share one
//   input stream; a fourth loader with E_LOG=P_LOG=3 gets its own stream.
//   A record-queue model predicts every output each cycle.
module tb_sort_chunk_loader;
    import sort_chunk_loader_pkg::*;

    localparam int P_LOG = 3;
    localparam int E_LOG = 1;
    localparam int DATW  = 64;
    localparam int KEYW  = 32;
    localparam int BW    = DATW << E_LOG;
    localparam int CW    = DATW << P_LOG;

    localparam logic [63:0] PAD_U = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] PAD_S = 64'h0000_0000_7FFF_FFFF;
    localparam logic [63:0] PAD_F = 64'h0000_0000_7F80_0000;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // ---------------- DUTs ----------------
    logic [BW-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [CW-1:0] in_data_p  = '0;
    logic          in_valid_p = 1'b0;
    logic          in_last_p  = 1'b0;
    state_t dbg_u, dbg_s, dbg_f, dbg_p;

    sort_chunk_loader_if #(.DATW(DATW), .P_LOG(P_LOG), .E_LOG(E_LOG)) bus_u ();
    sort_chunk_loader_if #(.DATW(DATW), .P_LOG(P_LOG), .E_LOG(E_LOG)) bus_s ();
    sort_chunk_loader_if #(.DATW(DATW), .P_LOG(P_LOG), .E_LOG(E_LOG)) bus_f ();
    sort_chunk_loader_if #(.DATW(DATW), .P_LOG(P_LOG), .E_LOG(P_LOG)) bus_p ();

    assign bus_u.IN_DATA = in_data;  assign bus_u.IN_VALID = in_valid;  assign bus_u.IN_LAST = in_last;
    assign bus_s.IN_DATA = in_data;  assign bus_s.IN_VALID = in_valid;  assign bus_s.IN_LAST = in_last;
    assign bus_f.IN_DATA = in_data;  assign bus_f.IN_VALID = in_valid;  assign bus_f.IN_LAST = in_last;
    assign bus_p.IN_DATA = in_data_p; assign bus_p.IN_VALID = in_valid_p; assign bus_p.IN_LAST = in_last_p;

    sort_chunk_loader #(.P_LOG(P_LOG), .E_LOG(E_LOG), .FLOAT("no"), .SIGNED("no"),
                        .DATW(DATW), .KEYW(KEYW))
        dut_u (.CLK(CLK), .RST(RST), .bus(bus_u), .dbg_state(dbg_u));
    sort_chunk_loader #(.P_LOG(P_LOG), .E_LOG(E_LOG), .FLOAT("no"), .SIGNED("yes"),
                        .DATW(DATW), .KEYW(KEYW))
        dut_s (.CLK(CLK), .RST(RST), .bus(bus_s), .dbg_state(dbg_s));
    sort_chunk_loader #(.P_LOG(P_LOG), .E_LOG(E_LOG), .FLOAT("yes"), .SIGNED("no"),
                        .DATW(DATW), .KEYW(KEYW))
        dut_f (.CLK(CLK), .RST(RST), .bus(bus_f), .dbg_state(dbg_f));
    sort_chunk_loader #(.P_LOG(P_LOG), .E_LOG(P_LOG), .FLOAT("no"), .SIGNED("no"),
                        .DATW(DATW), .KEYW(KEYW))
        dut_p (.CLK(CLK), .RST(RST), .bus(bus_p), .dbg_state(dbg_p));

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The chunk is a list of real records; emission happens when the list
    // reaches 8 records, or after (8 - records)/2 padding cycles following
    // IN_LAST. Slots past the real count hold the sentinel of each DUT.
    logic [DATW-1:0] m_rec[$];
    logic [DATW-1:0] m_out[8];
    int   m_cnt      = 0;
    int   m_pad_left = 0;
    bit   m_have     = 0;
    bit   m_en       = 0;
    bit   m_live     = 0;
    // pass-through model
    logic [CW-1:0] pm_data = '0;
    bit   pm_en   = 0;
    int   pm_cnt  = 0;

    function automatic void emit();
        m_cnt = m_rec.size();
        for (int s = 0; s < 8; s++) m_out[s] = (s < m_cnt) ? m_rec[s] : '0;
        m_rec.delete();
        m_have = 1;
        m_en   = 1;
    endfunction

    always @(posedge CLK) begin
        m_en  = 0;
        pm_en = 0;
        if (RST) begin
            m_live = 1;
            m_rec.delete();
            m_pad_left = 0;
            m_cnt  = 0;
            m_have = 0;
            pm_data = '0;
            pm_cnt  = 0;
        end else begin
            if (m_pad_left > 0) begin
                m_pad_left--;
                if (m_pad_left == 0) emit();
            end else if (in_valid) begin
                m_rec.push_back(in_data[63:0]);
                m_rec.push_back(in_data[127:64]);
                if (m_rec.size() == 8) emit();
                else if (in_last) m_pad_left = (8 - m_rec.size()) / 2;
            end
            if (in_valid_p) begin
                pm_en   = 1;
                pm_data = in_data_p;
                pm_cnt  = 8;
            end
        end
    end

    function automatic logic [CW-1:0] exp_chunk(input logic [63:0] pad);
        logic [CW-1:0] v;
        v = '0;
        if (m_have)
            for (int s = 0; s < 8; s++) v[s*64 +: 64] = (s < m_cnt) ? m_out[s] : pad;
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    int cyc = 0;
    int en_q[$];
    bit pt_phase = 0;

    always @(negedge CLK) begin
        cyc++;
        if (bus_u.OUT_EN) en_q.push_back(cyc);
        if (m_live) begin
            chk("ready_u", CW'(bus_u.IN_READY), CW'(!RST && m_pad_left == 0));
            chk("ready_s", CW'(bus_s.IN_READY), CW'(!RST && m_pad_left == 0));
            chk("ready_f", CW'(bus_f.IN_READY), CW'(!RST && m_pad_left == 0));
            chk("en_u", CW'(bus_u.OUT_EN), CW'(m_en));
            chk("en_s", CW'(bus_s.OUT_EN), CW'(m_en));
            chk("en_f", CW'(bus_f.OUT_EN), CW'(m_en));
            chk("cnt_u", CW'(bus_u.OUT_CNT), CW'(m_cnt));
            chk("cnt_s", CW'(bus_s.OUT_CNT), CW'(m_cnt));
            chk("cnt_f", CW'(bus_f.OUT_CNT), CW'(m_cnt));
            chk("data_u", bus_u.OUT_DATA, exp_chunk(PAD_U));
            chk("data_s", bus_s.OUT_DATA, exp_chunk(PAD_S));
            chk("data_f", bus_f.OUT_DATA, exp_chunk(PAD_F));
            chk("pt_ready", CW'(bus_p.IN_READY), CW'(!RST));
            chk("pt_en", CW'(bus_p.OUT_EN), CW'(pm_en));
            chk("pt_cnt", CW'(bus_p.OUT_CNT), CW'(pm_cnt));
            chk("pt_data", bus_p.OUT_DATA, pm_data);
            if (pt_phase) chk("pt_nopad", CW'(dbg_p), CW'(FILL));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input bit last);
        bit r;
        int tries;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tries    = 0;
        forever begin
            @(negedge CLK);
            r = bus_u.IN_READY;
            @(posedge CLK);
            #2;
            if (r) break;
            tries++;
            if (tries > 20) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_beat: ready never seen after %0d cycles", tries);
                break;
            end
        end
    endtask

    function automatic logic [BW-1:0] beat2(input logic [31:0] p0, k0, p1, k1);
        return {p1, k1, p0, k0};
    endfunction

    task automatic wait_en(input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            if (bus_u.OUT_EN) break;
            n++;
            if (n > 20) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: OUT_EN got 0 for %0d cycles, expected a pulse", nm, n);
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge CLK);
        #2;
        // reset values visible while RST is still high
        chk("rst_ready", CW'(bus_u.IN_READY), CW'(0));
        chk("rst_data", bus_u.OUT_DATA, '0);
        RST = 1'b0;

        // full chunk, keys descending 8..1, payloads 1..8
        for (int k = 0; k < 4; k++)
            send_beat(beat2(2*k+1, 8-2*k, 2*k+2, 7-2*k), k == 3);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_en("full_en");
        chk("full_slot0_key", CW'(bus_u.OUT_DATA[31:0]), CW'(8));
        chk("full_slot0_pay", CW'(bus_u.OUT_DATA[63:32]), CW'(1));
        chk("full_slot7_key", CW'(bus_u.OUT_DATA[7*64 +: 32]), CW'(1));
        chk("full_cnt", CW'(bus_u.OUT_CNT), CW'(8));
        idle(2);

        // partial flush: one beat with IN_LAST
        send_beat(beat2(32'hA, 5, 32'hB, 9), 1'b1);
        idle(0);
        wait_en("part_en");
        chk("part_slot1_key", CW'(bus_u.OUT_DATA[64 +: 32]), CW'(9));
        chk("part_pad_u", CW'(bus_u.OUT_DATA[2*64 +: 32]), CW'(32'hFFFF_FFFF));
        chk("part_pad_s", CW'(bus_s.OUT_DATA[2*64 +: 32]), CW'(32'h7FFF_FFFF));
        chk("part_pad_f", CW'(bus_f.OUT_DATA[7*64 +: 32]), CW'(32'h7F80_0000));
        chk("part_pad_pay", CW'(bus_u.OUT_DATA[2*64+32 +: 32]), CW'(0));
        chk("part_cnt", CW'(bus_u.OUT_CNT), CW'(2));
        idle(2);

        // back-to-back: 8 beats at full rate
        en_q.delete();
        for (int k = 0; k < 8; k++)
            send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(4);
        chk("b2b_pulses", CW'(en_q.size()), CW'(2));
        if (en_q.size() == 2) chk("b2b_spacing", CW'(en_q[1] - en_q[0]), CW'(4));

        // gap of 2 idle cycles between beats 2 and 3
        send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(2);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(3);

        // reset after 2 beats, then a clean chunk
        send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        for (int k = 0; k < 4; k++)
            send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(3);

        // IN_LAST without IN_VALID is ignored
        in_last = 1'b1;
        @(posedge CLK);
        #2;
        in_last = 1'b0;
        idle(6);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            else send_beat({$urandom, $urandom, $urandom, $urandom},
                           $urandom_range(0, 5) == 0);
        end
        idle(8);

        // pass-through loader: every beat is a chunk
        pt_phase = 1;
        in_data_p  = {16{$urandom}};
        in_valid_p = 1'b1;
        in_last_p  = 1'b1;
        @(posedge CLK);
        #2;
        in_valid_p = 1'b0;
        in_last_p  = 1'b0;
        @(negedge CLK);
        chk("pt_first_en", CW'(bus_p.OUT_EN), CW'(1));
        chk("pt_first_cnt", CW'(bus_p.OUT_CNT), CW'(8));
        @(posedge CLK);
        #2;
        for (int i = 0; i < 40; i++) begin
            for (int w = 0; w < 16; w++) in_data_p[w*32 +: 32] = $urandom;
            in_valid_p = ($urandom_range(0, 2) != 0);
            in_last_p  = ($urandom_range(0, 1) == 1);
            @(posedge CLK);
            #2;
        end
        in_valid_p = 1'b0;
        in_last_p  = 1'b0;
        repeat (4) @(posedge CLK);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
